// File: rtl/rv_decode_stage.sv
// rv_decode_stage
//   Pipelined RV64IM decode stage. It accepts a packet of LANES 32-bit
//   instructions and decodes each lane into register indices, a sign-extended
//   immediate, a micro-op code and flags. The decoded packet is registered and
//   offered downstream with a valid/ready handshake. A one-entry skid buffer
//   absorbs the cycle in which the consumer stalls, so in_ready depends only
//   on registered state. The stage also keeps a saturating count of illegal
//   lanes.
//
//   Optional feature macro: RV_DECODE_MEXT_EN
//     defined   : funct7=0000001 on OP/OP-32 decodes to MUL..REMU (uop 10-17)
//     undefined : those encodings are illegal, and no M decode logic exists
//
//   use_imm is set only by the OP-IMM / OP-IMM-32 forms. It marks that the
//   ALU second operand is the immediate. Loads, stores, branches and jumps
//   carry their immediate in imm, and their uop implies how it is used.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   in_valid/in_ready       input handshake
//   in_pc, in_instr,        packet: lane-0 PC, LANES instruction words,
//   in_mask                 per-lane valid
//   out_valid/out_ready     output handshake
//   out_pc, out_lane_valid  registered in_pc / in_mask
//   out_uop, out_rs1/rs2/rd per-lane micro-op and register indices
//   out_imm                 per-lane sign-extended immediate
//   out_use_imm/is_word/    per-lane flags
//   out_illegal
//   illegal_count           saturating count of illegal valid lanes accepted
module rv_decode_stage #(
  parameter int LANES = 2,
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [32*LANES-1:0]     in_instr,
  input  logic [LANES-1:0]        in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [6*LANES-1:0]      out_uop,
  output logic [5*LANES-1:0]      out_rs1,
  output logic [5*LANES-1:0]      out_rs2,
  output logic [5*LANES-1:0]      out_rd,
  output logic [XLEN*LANES-1:0]   out_imm,
  output logic [LANES-1:0]        out_use_imm,
  output logic [LANES-1:0]        out_is_word,
  output logic [LANES-1:0]        out_illegal,
  output logic [CNT_W-1:0]        illegal_count
);

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;

  localparam logic [5:0] UOP_ADD   = 6'd0;
  localparam logic [5:0] UOP_SUB   = 6'd1;
  localparam logic [5:0] UOP_SLL   = 6'd2;
  localparam logic [5:0] UOP_SLT   = 6'd3;
  localparam logic [5:0] UOP_SLTU  = 6'd4;
  localparam logic [5:0] UOP_XOR   = 6'd5;
  localparam logic [5:0] UOP_SRL   = 6'd6;
  localparam logic [5:0] UOP_SRA   = 6'd7;
  localparam logic [5:0] UOP_OR    = 6'd8;
  localparam logic [5:0] UOP_AND   = 6'd9;
`ifdef RV_DECODE_MEXT_EN
  localparam logic [5:0] UOP_MUL   = 6'd10;
`endif
  localparam logic [5:0] UOP_LB    = 6'd18;
  localparam logic [5:0] UOP_SB    = 6'd25;
  localparam logic [5:0] UOP_BEQ   = 6'd29;
  localparam logic [5:0] UOP_BNE   = 6'd30;
  localparam logic [5:0] UOP_BLT   = 6'd31;
  localparam logic [5:0] UOP_BGE   = 6'd32;
  localparam logic [5:0] UOP_BLTU  = 6'd33;
  localparam logic [5:0] UOP_BGEU  = 6'd34;
  localparam logic [5:0] UOP_LUI   = 6'd35;
  localparam logic [5:0] UOP_AUIPC = 6'd36;
  localparam logic [5:0] UOP_JAL   = 6'd37;
  localparam logic [5:0] UOP_JALR  = 6'd38;

  typedef struct packed {
    logic [5:0]      uop;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            is_word;
    logic            illegal;
  } lane_t;

  typedef struct packed {
    logic [XLEN-1:0]         pc;
    logic [LANES-1:0]        mask;
    lane_t [LANES-1:0]       lanes;
  } pkt_t;

  function automatic logic [5:0] alu_uop(input logic [2:0] f3);
    case (f3)
      3'b000:  return UOP_ADD;
      3'b001:  return UOP_SLL;
      3'b010:  return UOP_SLT;
      3'b011:  return UOP_SLTU;
      3'b100:  return UOP_XOR;
      3'b101:  return UOP_SRL;
      3'b110:  return UOP_OR;
      default: return UOP_AND;
    endcase
  endfunction

  function automatic lane_t decode_lane(input logic [31:0] ins);
    lane_t           d;
    logic            ok;
    logic [6:0]      opc;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    ok    = 1'b1;
    imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
    imm_s = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
    imm_j = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    shamt = {{(XLEN-6){1'b0}}, ins[25:20]};
    d     = '0;
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.rd  = ins[11:7];
    if (ins[1:0] != 2'b11) begin
      ok = 1'b0;
    end else begin
      case (opc)
        OPC_OP, OPC_OP32: begin
          d.is_word = (opc == OPC_OP32);
          case (f7)
            7'b0000000: begin
              d.uop = alu_uop(f3);
              if (d.is_word && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101))
                ok = 1'b0;
            end
            7'b0100000: begin
              if (f3 == 3'b000)      d.uop = UOP_SUB;
              else if (f3 == 3'b101) d.uop = UOP_SRA;
              else                   ok = 1'b0;
            end
`ifdef RV_DECODE_MEXT_EN
            7'b0000001: begin
              d.uop = UOP_MUL + {3'b000, f3};
              // RV64M W-forms exist only for MULW/DIVW/DIVUW/REMW/REMUW
              if (d.is_word && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011))
                ok = 1'b0;
            end
`endif
            default: ok = 1'b0;
          endcase
        end
        OPC_OPIMM: begin
          d.use_imm = 1'b1;
          d.rs2     = '0;
          d.imm     = imm_i;
          d.uop     = alu_uop(f3);
          if (f3 == 3'b001) begin
            d.imm = shamt;
            ok    = (ins[31:26] == 6'b000000);
          end else if (f3 == 3'b101) begin
            d.imm = shamt;
            d.uop = ins[30] ? UOP_SRA : UOP_SRL;
            ok    = (ins[31:26] == 6'b000000) || (ins[31:26] == 6'b010000);
          end
        end
        OPC_OPIMM32: begin
          d.use_imm = 1'b1;
          d.is_word = 1'b1;
          d.rs2     = '0;
          d.uop     = alu_uop(f3);
          case (f3)
            3'b000: d.imm = imm_i;
            3'b001: begin
              d.imm = shamt;
              ok    = (ins[31:25] == 7'b0000000);
            end
            3'b101: begin
              d.imm = shamt;
              d.uop = ins[30] ? UOP_SRA : UOP_SRL;
              ok    = ((ins[31:26] == 6'b000000) || (ins[31:26] == 6'b010000)) && !ins[25];
            end
            default: ok = 1'b0;
          endcase
        end
        OPC_LOAD: begin
          d.rs2 = '0;
          d.imm = imm_i;
          d.uop = UOP_LB + {3'b000, f3};
          if (f3 == 3'b111) ok = 1'b0;
        end
        OPC_STORE: begin
          d.rd  = '0;
          d.imm = imm_s;
          d.uop = UOP_SB + {4'b0000, f3[1:0]};
          if (f3[2]) ok = 1'b0;
        end
        OPC_BRANCH: begin
          d.rd  = '0;
          d.imm = imm_b;
          case (f3)
            3'b000:  d.uop = UOP_BEQ;
            3'b001:  d.uop = UOP_BNE;
            3'b100:  d.uop = UOP_BLT;
            3'b101:  d.uop = UOP_BGE;
            3'b110:  d.uop = UOP_BLTU;
            3'b111:  d.uop = UOP_BGEU;
            default: ok = 1'b0;
          endcase
        end
        OPC_LUI, OPC_AUIPC: begin
          d.rs1 = '0;
          d.rs2 = '0;
          d.imm = imm_u;
          d.uop = (opc == OPC_LUI) ? UOP_LUI : UOP_AUIPC;
        end
        OPC_JAL: begin
          d.rs1 = '0;
          d.rs2 = '0;
          d.imm = imm_j;
          d.uop = UOP_JAL;
        end
        OPC_JALR: begin
          d.rs2 = '0;
          d.imm = imm_i;
          d.uop = UOP_JALR;
          ok    = (f3 == 3'b000);
        end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  pkt_t             dec;
  pkt_t             out_q;
  pkt_t             skid_q;
  logic             skid_full;
  logic             acc;
  logic [CNT_W:0]   n_ill;
  logic [CNT_W:0]   cnt_sum;

  always_comb begin
    dec      = '0;
    dec.pc   = in_pc;
    dec.mask = in_mask;
    for (int i = 0; i < LANES; i++) begin
      if (in_mask[i]) dec.lanes[i] = decode_lane(in_instr[32*i +: 32]);
    end
  end

  always_comb begin
    n_ill = '0;
    for (int i = 0; i < LANES; i++) n_ill = n_ill + {{CNT_W{1'b0}}, dec.lanes[i].illegal};
    cnt_sum = {1'b0, illegal_count} + n_ill;
  end

  // in_ready comes only from the skid flag, so out_ready never reaches it
  assign in_ready = !skid_full;
  assign acc      = in_valid && !skid_full;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q         <= '0;
      skid_q        <= '0;
      out_valid     <= 1'b0;
      skid_full     <= 1'b0;
      illegal_count <= '0;
    end else begin
      if (!out_valid || out_ready) begin
        if (skid_full) begin
          out_q     <= skid_q;
          out_valid <= 1'b1;
          skid_full <= 1'b0;
        end else if (acc) begin
          out_q     <= dec;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (acc) begin
        skid_q    <= dec;
        skid_full <= 1'b1;
      end
      if (acc) illegal_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  assign out_pc         = out_q.pc;
  assign out_lane_valid = out_q.mask;

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign out_uop[6*g +: 6]        = out_q.lanes[g].uop;
    assign out_rs1[5*g +: 5]        = out_q.lanes[g].rs1;
    assign out_rs2[5*g +: 5]        = out_q.lanes[g].rs2;
    assign out_rd[5*g +: 5]         = out_q.lanes[g].rd;
    assign out_imm[XLEN*g +: XLEN]  = out_q.lanes[g].imm;
    assign out_use_imm[g]           = out_q.lanes[g].use_imm;
    assign out_is_word[g]           = out_q.lanes[g].is_word;
    assign out_illegal[g]           = out_q.lanes[g].illegal;
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Testbench for rv_decode_stage (LANES=2, XLEN=64, CNT_W=4).
// Expected packets are queued on acceptance and compared while on the output.
module tb_rv_decode_stage;

  localparam int LANES = 2;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_pc;
  logic [32*LANES-1:0]   in_instr;
  logic [LANES-1:0]      in_mask;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [LANES-1:0]      out_lane_valid;
  logic [6*LANES-1:0]    out_uop;
  logic [5*LANES-1:0]    out_rs1, out_rs2, out_rd;
  logic [XLEN*LANES-1:0] out_imm;
  logic [LANES-1:0]      out_use_imm, out_is_word, out_illegal;
  logic [CNT_W-1:0]      illegal_count;

  rv_decode_stage #(.LANES(LANES), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_lane_valid(out_lane_valid), .out_uop(out_uop), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_use_imm(out_use_imm), .out_is_word(out_is_word), .out_illegal(out_illegal),
    .illegal_count(illegal_count));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  uop;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic        ui, iw, ill;
  } le_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [1:0]  mask;
    logic [31:0] i1, i0;
    le_t         l1, l0;
  } pk_t;

  pk_t  q[$];
  pk_t  exp_cur;
  int   exp_cnt = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   run = 1'b0;

  function automatic le_t le(input int uop, input int rs1, input int rs2, input int rd,
                             input logic [63:0] imm, input bit ui, input bit iw);
    le_t e;
    e.uop = uop[5:0]; e.rs1 = rs1[4:0]; e.rs2 = rs2[4:0]; e.rd = rd[4:0];
    e.imm = imm; e.ui = ui; e.iw = iw; e.ill = 1'b0;
    return e;
  endfunction

  function automatic le_t ill();
    le_t e;
    e = '0;
    e.ill = 1'b1;
    return e;
  endfunction

  function automatic pk_t pk(input logic [63:0] pc, input logic [1:0] mask,
                             input logic [31:0] i0, input le_t e0,
                             input logic [31:0] i1, input le_t e1);
    pk_t p;
    p.pc = pc; p.mask = mask; p.i0 = i0; p.i1 = i1;
    p.l0 = mask[0] ? e0 : '0;
    p.l1 = mask[1] ? e1 : '0;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: compare the head while it is on the output, pop when drained.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      exp_cnt = 0;
    end else if (run) begin
      chk("illegal_count", {60'b0, illegal_count}, exp_cnt);
      if (out_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          $error("FAIL unexpected_packet: observed pc %0h expected none", out_pc);
        end else begin
          pk_t h;
          h = q[0];
          chk("pc", out_pc, h.pc);
          chk("lane_valid", {62'b0, out_lane_valid}, {62'b0, h.mask});
          for (int i = 0; i < LANES; i++) begin
            le_t e;
            e = (i == 0) ? h.l0 : h.l1;
            chk($sformatf("uop%0d", i), {58'b0, out_uop[6*i +: 6]}, {58'b0, e.uop});
            chk($sformatf("rs1_%0d", i), {59'b0, out_rs1[5*i +: 5]}, {59'b0, e.rs1});
            chk($sformatf("rs2_%0d", i), {59'b0, out_rs2[5*i +: 5]}, {59'b0, e.rs2});
            chk($sformatf("rd%0d", i), {59'b0, out_rd[5*i +: 5]}, {59'b0, e.rd});
            chk($sformatf("imm%0d", i), out_imm[64*i +: 64], e.imm);
            chk($sformatf("flags%0d", i),
                {61'b0, out_use_imm[i], out_is_word[i], out_illegal[i]},
                {61'b0, e.ui, e.iw, e.ill});
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(exp_cur);
        exp_cnt = exp_cnt + int'(exp_cur.l0.ill) + int'(exp_cur.l1.ill);
        if (exp_cnt > 15) exp_cnt = 15;
      end
    end
  end

  task automatic send(input pk_t p);
    int n;
    in_valid = 1'b1;
    in_pc    = p.pc;
    in_instr = {p.i1, p.i0};
    in_mask  = p.mask;
    exp_cur  = p;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      n_chk++;
      $error("FAIL accept_timeout: observed in_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_chk++;
      $error("FAIL drain_timeout: observed %0d queued expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] I_ILL = 32'hFFFF_FFFF;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    in_mask   = '0;
    out_ready = 1'b1;
    exp_cur   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_count", {60'b0, illegal_count}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_imm", out_imm[63:0], 64'd0);
    chk("rst_out_uop", {52'b0, out_uop}, 64'd0);
    reset_n = 1'b1;
    run     = 1'b1;

    // ADDI x1,x0,10 / SUB x2,x1,x2
    send(pk(64'h1000, 2'b11, 32'h00A00093, le(0, 0, 0, 1, 64'd10, 1, 0),
                             32'h40208133, le(1, 1, 2, 2, 64'd0, 0, 0)));
    chk("latency_out_valid", {63'b0, out_valid}, 64'd1);
    // SW x1,-4(x2) / BEQ x0,x0,-4
    send(pk(64'h2000, 2'b11, 32'hFE112E23, le(27, 2, 1, 0, -64'sd4, 0, 0),
                             32'hFE000EE3, le(29, 0, 0, 0, -64'sd4, 0, 0)));
    // JAL x1,-1MiB / all-ones illegal
    send(pk(64'h3000, 2'b11, 32'h800000EF, le(37, 0, 0, 1, -64'sd1048576, 0, 0),
                             I_ILL, ill()));
    // unlisted opcode / MUL x0,x0,x0
`ifdef RV_DECODE_MEXT_EN
    send(pk(64'h4000, 2'b11, 32'h0000007F, ill(), 32'h02000033, le(10, 0, 0, 0, 64'd0, 0, 0)));
`else
    send(pk(64'h4000, 2'b11, 32'h0000007F, ill(), 32'h02000033, ill()));
`endif
    wait_drain();
`ifdef RV_DECODE_MEXT_EN
    chk("count_after_illegals", {60'b0, illegal_count}, 64'd2);
`else
    chk("count_after_illegals", {60'b0, illegal_count}, 64'd3);
`endif
    // SRAI x1,x1,3 / ADDIW x5,x6,-1
    send(pk(64'h5000, 2'b11, 32'h4030D093, le(7, 1, 0, 1, 64'd3, 1, 0),
                             32'hFFF3029B, le(0, 6, 0, 5, -64'sd1, 1, 1)));
    // LD x3,8(x2) / LUI x7,0x12345
    send(pk(64'h6000, 2'b11, 32'h00813183, le(21, 2, 0, 3, 64'd8, 0, 0),
                             32'h123453B7, le(35, 0, 0, 7, 64'h12345000, 0, 0)));
    // SLLIW with shamt[5]=1 / SRLI with bad funct7 bits
    send(pk(64'h7000, 2'b11, 32'h0200909B, ill(), 32'h2030D093, ill()));
    // masked lane carrying an illegal word must not count
    send(pk(64'h8000, 2'b01, 32'h00000013, le(0, 0, 0, 0, 64'd0, 1, 0), I_ILL, ill()));
    // empty mask still produces a packet
    send(pk(64'h9000, 2'b00, I_ILL, ill(), I_ILL, ill()));
    wait_drain();

    // backpressure: A to output, B to skid, C refused until drain
    out_ready = 1'b0;
    send(pk(64'hA000, 2'b11, 32'h00A00093, le(0, 0, 0, 1, 64'd10, 1, 0),
                             32'h40208133, le(1, 1, 2, 2, 64'd0, 0, 0)));
    send(pk(64'hB000, 2'b11, 32'hFE112E23, le(27, 2, 1, 0, -64'sd4, 0, 0),
                             32'h0000007F, ill()));
    in_valid = 1'b1;
    in_pc    = 64'hC000;
    @(negedge clk);
    chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(pk(64'hC000, 2'b10, 32'h0, le(0, 0, 0, 0, 64'd0, 0, 0),
                             32'h800000EF, le(37, 0, 0, 1, -64'sd1048576, 0, 0)));
    wait_drain();

    // reset with output and skid both full
    out_ready = 1'b0;
    send(pk(64'hD000, 2'b11, I_ILL, ill(), I_ILL, ill()));
    send(pk(64'hE000, 2'b11, I_ILL, ill(), 32'h00A00093, le(0, 0, 0, 1, 64'd10, 1, 0)));
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("midrst_count", {60'b0, illegal_count}, 64'd0);
    reset_n   = 1'b1;
    out_ready = 1'b1;

    // 20 illegal lanes saturate a 4-bit counter at 15
    for (int k = 0; k < 10; k++)
      send(pk(64'hF000 + 64'(k * 8), 2'b11, I_ILL, ill(), I_ILL, ill()));
    wait_drain();
    chk("count_saturated", {60'b0, illegal_count}, 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
